// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline (option: PIPE_PERF_CNT_EN)
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        mem_branch_taken,
  input  logic        mem_access,
  input  logic        mem_overflow,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        ex_mem_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        epc_write,
  output logic [1:0]  cause,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP} state_t;

  // Control word: {pc_write, pc_sel, if_id/id_ex/ex_mem write, if_id/id_ex/ex_mem/mem_wb flush, epc_write}
  localparam logic [10:0] CTL_DEFAULT  = {1'b1, 2'b00, 3'b111, 4'b0000, 1'b0};
  localparam logic [10:0] CTL_FREEZE   = {1'b0, 2'b00, 3'b000, 4'b0001, 1'b0};
  localparam logic [10:0] CTL_BRANCH   = {1'b1, 2'b01, 3'b111, 4'b1110, 1'b0};
  localparam logic [10:0] CTL_LOAD_USE = {1'b0, 2'b00, 3'b011, 4'b0100, 1'b0};
  localparam logic [10:0] CTL_TRAP     = {1'b1, 2'b10, 3'b111, 4'b1111, 1'b1};
  localparam logic [7:0]  WAIT_LAST    = 8'(MEM_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [1:0]  cause_q;
  logic [10:0] ctl;
  logic        load_use;
  logic        mem_stall;

  assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  assign mem_stall = mem_access && !dmem_ready;

  // Decode the control word from current state and hazard inputs
  always_comb begin
    ctl = CTL_DEFAULT;
    case (state)
      RUN: begin
        if (mem_overflow)          ctl = CTL_FREEZE;
        else if (mem_stall)        ctl = CTL_FREEZE;
        else if (mem_branch_taken) ctl = CTL_BRANCH;
        else if (load_use)         ctl = CTL_LOAD_USE;
      end
      MEM_WAIT: if (!dmem_ready) ctl = CTL_FREEZE;
      TRAP:     ctl = CTL_TRAP;
      default:  ctl = CTL_DEFAULT;
    endcase
  end

  // Outputs are forced low while reset is held
  assign {pc_write, pc_sel, if_id_write, id_ex_write, ex_mem_write,
          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, epc_write} = rst_n ? ctl : 11'd0;
  assign cause = cause_q;

  // Sequence memory waits, timeouts and traps; latch the trap cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      cause_q  <= 2'b00;
    end else begin
      case (state)
        RUN: begin
          if (mem_overflow) begin
            state   <= TRAP;
            cause_q <= 2'b01;
          end else if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= TRAP;
            cause_q  <= 2'b10;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        TRAP:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q;

  // Count cycles with the PC held, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= 32'd0;
    else if (!ctl[10] && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic id_uses_rt, ex_mem_read, mem_branch_taken, mem_access, mem_overflow, dmem_ready;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, epc_write;
  logic [1:0] pc_sel, cause;
  logic [31:0] stall_cycles;
  logic [10:0] dvec;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_branch_taken(mem_branch_taken),
    .mem_access(mem_access), .mem_overflow(mem_overflow), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .pc_sel(pc_sel), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .epc_write(epc_write),
    .cause(cause), .stall_cycles(stall_cycles)
  );

  assign dvec = {pc_write, pc_sel, if_id_write, id_ex_write, ex_mem_write,
                 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, epc_write};

  typedef struct packed {
    logic [4:0] rs; logic [4:0] rt; logic urt; logic lr; logic [4:0] rd;
    logic br; logic acc; logic ovf; logic rdy;
  } in_t;

  typedef struct { in_t in; logic [10:0] exp; } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model state: stalled memory cycles so far, pending trap, cause, stall count
  int          m_waited;
  bit          m_trap;
  logic [1:0]  m_cause;
  longint      m_stall;

  function automatic logic [10:0] mk(bit pcw, logic [1:0] sel, logic [2:0] w, logic [3:0] f, bit epc);
    return {pcw, sel, w, f, epc};
  endfunction

  function automatic in_t mkin(int rs, int rt, bit urt, bit lr, int rd, bit br, bit acc, bit ovf, bit rdy);
    in_t x;
    x.rs = 5'(rs); x.rt = 5'(rt); x.urt = urt; x.lr = lr; x.rd = 5'(rd);
    x.br = br; x.acc = acc; x.ovf = ovf; x.rdy = rdy;
    return x;
  endfunction

  function automatic logic [10:0] model_out(in_t x);
    logic [10:0] dflt, frz;
    dflt = mk(1, 2'b00, 3'b111, 4'b0000, 0);
    frz  = mk(0, 2'b00, 3'b000, 4'b0001, 0);
    if (m_trap) return mk(1, 2'b10, 3'b111, 4'b1111, 1);
    if (m_waited > 0) return x.rdy ? dflt : frz;
    if (x.ovf) return frz;
    if (x.acc && !x.rdy) return frz;
    if (x.br) return mk(1, 2'b01, 3'b111, 4'b1110, 0);
    if (x.lr && x.rd != 0 && (x.rd == x.rs || (x.urt && x.rd == x.rt)))
      return mk(0, 2'b00, 3'b011, 4'b0100, 0);
    return dflt;
  endfunction

  task automatic model_step(in_t x, logic [10:0] o);
`ifdef PIPE_PERF_CNT_EN
    if (!o[10] && m_stall < 64'hFFFF_FFFF) m_stall++;
`endif
    if (m_trap) begin
      m_trap = 0;
    end else if (m_waited > 0) begin
      if (x.rdy) m_waited = 0;
      else if (m_waited + 1 == TO) begin m_trap = 1; m_cause = 2'b10; m_waited = 0; end
      else m_waited++;
    end else if (x.ovf) begin
      m_trap = 1; m_cause = 2'b01;
    end else if (x.acc && !x.rdy) begin
      m_waited = 1;
    end
  endtask

  task automatic model_reset();
    m_waited = 0; m_trap = 0; m_cause = 2'b00; m_stall = 0;
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(in_t x);
    id_rs = x.rs; id_rt = x.rt; id_uses_rt = x.urt; ex_mem_read = x.lr; ex_rd = x.rd;
    mem_branch_taken = x.br; mem_access = x.acc; mem_overflow = x.ovf; dmem_ready = x.rdy;
  endtask

  // One clock: drive at posedge+1, compare at negedge, advance the model
  task automatic cycle(in_t x);
    logic [10:0] o;
    drive(x);
    @(negedge clk);
    o = model_out(x);
    check("ctl", 64'(dvec), 64'(o));
    check("cause", 64'(cause), 64'(m_cause));
    check("stall", 64'(stall_cycles), 64'(m_stall));
    model_step(x, o);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(string name);
    check({name, "_ctl"}, 64'(dvec), 64'd0);
    check({name, "_cause"}, 64'(cause), 64'd0);
    check({name, "_stall"}, 64'(stall_cycles), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  in_t  idle, ld, wt;
  vec_t tbl[10];

  initial begin
    idle = mkin(0, 0, 0, 0, 0, 0, 0, 0, 1);
    model_reset();
    drive(idle);
    rst_n = 1'b0;
    #12;
    check_all_zero("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    tbl[0] = '{mkin(0, 0, 0, 0, 0, 0, 0, 0, 1), mk(1, 2'b00, 3'b111, 4'b0000, 0)};
    tbl[1] = '{mkin(5, 0, 0, 1, 5, 0, 0, 0, 1), mk(0, 2'b00, 3'b011, 4'b0100, 0)};
    tbl[2] = '{mkin(5, 0, 0, 1, 7, 0, 0, 0, 1), mk(1, 2'b00, 3'b111, 4'b0000, 0)};
    tbl[3] = '{mkin(3, 5, 1, 1, 5, 0, 0, 0, 1), mk(0, 2'b00, 3'b011, 4'b0100, 0)};
    tbl[4] = '{mkin(3, 5, 0, 1, 5, 0, 0, 0, 1), mk(1, 2'b00, 3'b111, 4'b0000, 0)};
    tbl[5] = '{mkin(0, 0, 1, 1, 0, 0, 0, 0, 1), mk(1, 2'b00, 3'b111, 4'b0000, 0)};
    tbl[6] = '{mkin(5, 5, 1, 0, 5, 0, 0, 0, 1), mk(1, 2'b00, 3'b111, 4'b0000, 0)};
    tbl[7] = '{mkin(5, 0, 0, 1, 5, 1, 0, 0, 1), mk(1, 2'b01, 3'b111, 4'b1110, 0)};
    tbl[8] = '{mkin(0, 0, 0, 0, 0, 0, 1, 0, 1), mk(1, 2'b00, 3'b111, 4'b0000, 0)};
    tbl[9] = '{mkin(0, 0, 0, 0, 0, 1, 1, 0, 1), mk(1, 2'b01, 3'b111, 4'b1110, 0)};

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].in);
      #1;
      check($sformatf("tbl%0d", i), 64'(dvec), 64'(tbl[i].exp));
      cycle(tbl[i].in);
    end

    // Memory wait: three stalled cycles, then completion
    do_reset();
    wt = mkin(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(wt);
      #1;
      check("memwait_freeze", 64'(dvec), 64'(mk(0, 2'b00, 3'b000, 4'b0001, 0)));
      cycle(wt);
    end
    cycle(mkin(0, 0, 0, 0, 0, 0, 1, 0, 1));
    drive(idle);
    #1;
`ifdef PIPE_PERF_CNT_EN
    check("memwait_stall", 64'(stall_cycles), 64'd3);
`else
    check("memwait_stall", 64'(stall_cycles), 64'd0);
`endif
    cycle(idle);

    // Bus timeout: TO stalled cycles, then TRAP
    for (int i = 0; i < TO; i++) cycle(wt);
    drive(idle);
    #1;
    check("timeout_trap", 64'(dvec), 64'(mk(1, 2'b10, 3'b111, 4'b1111, 1)));
    cycle(idle);
    check("timeout_cause", 64'(cause), 64'd2);
    cycle(idle);

    // Overflow: one freeze, then TRAP
    cycle(mkin(0, 0, 0, 0, 0, 0, 0, 1, 1));
    drive(idle);
    #1;
    check("ovf_trap", 64'(dvec), 64'(mk(1, 2'b10, 3'b111, 4'b1111, 1)));
    cycle(idle);
    check("ovf_cause", 64'(cause), 64'd1);
    cycle(idle);

    // Reset in the second stalled cycle: no trap afterwards
    do_reset();
    cycle(wt);
    drive(wt);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midwait");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      drive(idle);
      #1;
      check("postrst_run", 64'(dvec), 64'(mk(1, 2'b00, 3'b111, 4'b0000, 0)));
      cycle(idle);
    end
    check("postrst_cause", 64'(cause), 64'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      in_t x;
      x.rs  = 5'($urandom_range(0, 3));
      x.rt  = 5'($urandom_range(0, 3));
      x.rd  = 5'($urandom_range(0, 3));
      x.urt = 1'($urandom_range(0, 1));
      x.lr  = 1'($urandom_range(0, 1));
      x.br  = ($urandom_range(0, 5) == 0);
      x.acc = ($urandom_range(0, 2) == 0);
      x.ovf = ($urandom_range(0, 19) == 0);
      x.rdy = ($urandom_range(0, 2) != 0);
      cycle(x);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It decodes hazards from the ID, EX and MEM stages and drives the write-enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers and the PC.
- Combinational: load-use hazards and taken-branch redirects.
- Sequenced by an FSM: multi-cycle data-memory waits (with timeout) and overflow traps.

## Interface
Parameters:
- MEM_TIMEOUT, 16: max consecutive MEM_WAIT cycles before bus-error trap; legal range 2..255.

Ports:
- clk  in  1  pipeline clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of EX instruction
- mem_branch_taken  in  1  EX/MEM branch_out AND zero_flag_out (resolved in MEM)
- mem_access  in  1  EX/MEM memory_read_out OR memory_write_out
- mem_overflow  in  1  EX/MEM overflow_flag_out
- dmem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC register enable
- pc_sel  out  2  PC source:
  - 00 = pc+4
  - 01 = branch target
  - 10 = trap vector
- if_id_write, id_ex_write, ex_mem_write  out  1 each  stage register enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load a bubble
- epc_write  out  1  capture EX/MEM pc_out into EPC
- cause  out  2  registered trap cause:
  - 00 = none
  - 01 = overflow
  - 10 = bus timeout
- stall_cycles  out  32  stall performance counter (see Configuration)

## Operation
FSM states: RUN, MEM_WAIT, TRAP. Reset state RUN.

Default outputs: every `*_write` = 1, every `*_flush` = 0, pc_sel = 00, epc_write = 0.

RUN: evaluate conditions in strict priority order; the first true condition applies.
1. mem_overflow → freeze:
   - all `*_write` = 0, pc_write = 0, mem_wb_flush = 1
   - next state TRAP; cause <= 01
2. mem_access && !dmem_ready → freeze as above.
   - Next state MEM_WAIT; wait counter <= 1.
3. mem_branch_taken → redirect:
   - pc_sel = 01
   - if_id_flush = id_ex_flush = ex_mem_flush = 1
   - stay in RUN
4. Load-use: ex_mem_read && ex_rd != 0 && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt))
   - pc_write = 0, if_id_write = 0, id_ex_flush = 1
   - stay in RUN
   - Re-evaluated every cycle, so the bubble lasts exactly one cycle.

MEM_WAIT:
- dmem_ready = 1: default outputs (pipeline advances); next state RUN.
- Otherwise: freeze as above, counter increments.
- Counter == MEM_TIMEOUT - 1 with dmem_ready = 0: next state TRAP; cause <= 10.
- Overflow and branch inputs are ignored in MEM_WAIT.

TRAP (exactly one cycle):
- pc_sel = 10, pc_write = 1, epc_write = 1
- if_id_flush = id_ex_flush = ex_mem_flush = mem_wb_flush = 1
- next state RUN

Other rules:
- cause holds its value until the next trap.
- Flush and write both asserted on a register: flush wins (stage registers implement it that way).

## Timing
- Hazard outputs are combinational from current state and inputs; no added latency.
- Load-use bubble: 1 cycle.
- Branch penalty: 3 squashed instructions.
- Overflow trap: 2 cycles (freeze, then TRAP).
- Memory stall: N cycles, where N = cycles dmem_ready stays low.
- Bus timeout: trap taken in the cycle after MEM_TIMEOUT stalled cycles.
- While rst_n = 0, all outputs are 0: state RUN, counter 0, cause 00, stall_cycles 0.
- Asynchronous reset mid-MEM_WAIT or mid-TRAP returns to RUN immediately; no trap is taken.
- rst_n deassertion is synchronised externally.

## Configuration
- PIPE_PERF_CNT_EN defined: stall_cycles increments each cycle pc_write = 0 outside reset and saturates at 0xFFFFFFFF.
- Not defined: counter logic is absent and stall_cycles is tied to 0. The port is always present.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5 for one cycle → pc_write=0, if_id_write=0, id_ex_flush=1 that cycle; defaults the next cycle.
- Branch vs load-use: mem_branch_taken=1 together with the load-use condition → pc_sel=01, three flushes, pc_write=1.
- Memory wait: mem_access=1 with dmem_ready low for 3 cycles, then high → 3 freeze cycles with mem_wb_flush=1, then advance; stall_cycles=3 (macro on).
- Bus timeout: MEM_TIMEOUT=4, dmem_ready held 0 → 4 freeze cycles, then TRAP with pc_sel=10, epc_write=1; cause=10.
- Overflow: mem_overflow=1 in RUN → 1 freeze cycle, then TRAP with all four flushes; cause=01.
- Reset mid-wait: rst_n=0 in the 2nd MEM_WAIT cycle → all outputs 0 asynchronously; after release, state RUN, no trap, cause=00.
